msg_queue: RTL and testbench
============================

Name: msg_queue

Overview:
Downstream stage of the AXI-stream message parser. It captures each one-cycle message pulse (valid/length/data/error) into a DEPTH-entry message FIFO and re-presents messages on a valid/ready interface, so consumers can apply backpressure. The parser itself has no backpressure.
- Sanitises lengths and zero-masks bytes beyond the message length.
- Counts messages dropped on overflow.

Parameters:
MAX_MSG_BYTES, 32, width in bytes of the message data bus; must match the parser.
DEPTH, 4, number of message entries; power of two, >= 2.
CNT_WIDTH, 16, width of the drop counter.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
in_msg_valid  input  1  one-cycle message strobe from the parser
in_msg_length  input  16  message length in bytes
in_msg_data  input  8*MAX_MSG_BYTES  message data, byte 0 on [7:0]
in_msg_error  input  1  parser error flag
out_valid  output  1  head message available
out_ready  input  1  consumer accepts head message
out_length  output  16  head message length
out_data  output  8*MAX_MSG_BYTES  head message data
out_error  output  1  head message error flag
full  output  1  level == DEPTH
empty  output  1  level == 0
level  output  $clog2(DEPTH)+1  number of stored messages
drop_count  output  CNT_WIDTH  saturating count of dropped messages
clear_stats  input  1  synchronous clear of drop_count

Behaviour:
- Reset (rst low, async): wr/rd pointers = 0, level = 0. All outputs 0 except empty = 1. Storage contents are don't-care.
- Reset mid-operation: all queued messages are discarded. After release, the queue is empty.
- Pointers: $clog2(DEPTH) index bits plus one wrap bit; wrap-around is natural modulo DEPTH.
- Full when the pointer indices are equal and the wrap bits differ. Empty when the pointers are identical.
- pop = out_valid && out_ready. Increments rd_ptr.
- push = in_msg_valid && (!full || pop). Writes the entry at wr_ptr and increments wr_ptr.
- Full with simultaneous push and pop: both succeed; level stays DEPTH.
- Empty with push: out_valid rises the next cycle (1-cycle latency). There is no same-cycle bypass.
- out_* are first-word-fall-through from the head entry.
  - out_length, out_data and out_error hold stable while out_valid is high and out_ready is low.
  - When empty, out_* are 0.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Drop: in_msg_valid && full && !pop. The message is discarded and drop_count increments, saturating at all-ones.
- clear_stats sets drop_count to 0. If a drop coincides with clear_stats, drop_count becomes 1.
- Length sanitisation on write:
  - If in_msg_length == 0 or in_msg_length > MAX_MSG_BYTES, the stored error is forced to 1 and the length is stored unchanged.
  - Otherwise the stored error = in_msg_error.
- Data masking on write: byte i is stored as 0 when i >= in_msg_length, otherwise as the input byte.
  - Length 0 stores all zeros.
  - Length > MAX_MSG_BYTES stores all bytes unmasked.
- out_valid must never be asserted while empty. A pop while empty is impossible by construction.

Optional Feature:
MSGQ_DROP_ERR_EN
- Defined: a message whose stored error would be 1 (parser error or sanitisation failure) is never written. It increments drop_count (same saturation and clear rules) regardless of full, and out_error is tied to 0.
- Undefined: error messages are queued and forwarded with out_error = 1, as described above.

Test Plan:
1. Reset, then a single push of length 5, data 0xFFFF...FF, out_ready = 1 -> out_valid high one cycle later; out_length = 5; out_data = 0x000...00FFFFFFFFFF; out_error = 0; then empty = 1.
2. Push 5 messages (lengths 1..5) with DEPTH = 4 and out_ready = 0 -> full = 1, level = 4, drop_count = 1. Then out_ready = 1 -> messages pop in order with lengths 1, 2, 3, 4.
3. Queue full plus simultaneous push (length 8) and pop -> level stays 4, drop_count unchanged, the length-8 message emerges 4th.
4. Push length 0, then length 40 with in_msg_error = 0 -> both out_error = 1. Length-0 data is all zeros; length-40 data is unmasked. With MSGQ_DROP_ERR_EN: neither appears and drop_count = 2.
5. Force 2^CNT_WIDTH+3 drops -> drop_count saturates at 0xFFFF. clear_stats asserted together with a drop -> drop_count = 1.
6. Assert rst low with 3 messages queued and out_valid high -> out_valid = 0, level = 0, empty = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/msg_queue_if.sv
// Message bus between the parser/consumer side (master) and msg_queue (slave).
// Carries the one-cycle ingress message pulse and the valid/ready egress stream.
interface msg_queue_if #(
  parameter int MAX_MSG_BYTES = 32
);
  logic                       in_msg_valid;
  logic [15:0]                in_msg_length;
  logic [8*MAX_MSG_BYTES-1:0] in_msg_data;
  logic                       in_msg_error;
  logic                       out_valid;
  logic                       out_ready;
  logic [15:0]                out_length;
  logic [8*MAX_MSG_BYTES-1:0] out_data;
  logic                       out_error;

  modport master (
    output in_msg_valid, in_msg_length, in_msg_data, in_msg_error, out_ready,
    input  out_valid, out_length, out_data, out_error
  );

  modport slave (
    input  in_msg_valid, in_msg_length, in_msg_data, in_msg_error, out_ready,
    output out_valid, out_length, out_data, out_error
  );
endinterface

// File: rtl/msg_queue.sv
// msg_queue: DEPTH-entry message FIFO behind the AXI-stream message parser.
// Captures one-cycle message pulses, sanitises length/error, zero-masks bytes
// beyond the length, and re-presents messages first-word-fall-through on a
// valid/ready interface. Overflowing messages are dropped and counted.
// Optional build macro MSGQ_DROP_ERR_EN: error messages are dropped (counted)
// instead of queued, and out_error is tied low.
module msg_queue #(
  parameter int MAX_MSG_BYTES = 32,
  parameter int DEPTH         = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  msg_queue_if.slave                bus,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level,
  output logic [CNT_WIDTH-1:0]      drop_count,
  input  logic                      clear_stats
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = 8 * MAX_MSG_BYTES;
  localparam logic [AW:0]          PTR_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic [15:0]   len_mem_q  [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
`ifndef MSGQ_DROP_ERR_EN
  logic          err_mem_q  [DEPTH];
`endif

  logic          empty_w, full_w, pop, push, drop;
  logic          bad_len, err_wr;
  logic [DW-1:0] data_wr;

  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop     = !empty_w && bus.out_ready;

  assign bad_len = (bus.in_msg_length == 16'd0) ||
                   ({16'd0, bus.in_msg_length} > 32'(MAX_MSG_BYTES));
  assign err_wr  = bad_len || bus.in_msg_error;

`ifdef MSGQ_DROP_ERR_EN
  assign push = bus.in_msg_valid && !err_wr && (!full_w || pop);
  assign drop = bus.in_msg_valid && (err_wr || (full_w && !pop));
`else
  assign push = bus.in_msg_valid && (!full_w || pop);
  assign drop = bus.in_msg_valid && full_w && !pop;
`endif

  assign full       = full_w;
  assign empty      = empty_w;
  assign level      = wr_ptr_q - rd_ptr_q;
  assign drop_count = drop_cnt_q;

  // Zero every byte at or beyond the message length before storing.
  always_comb begin
    data_wr = '0;
    for (int unsigned i = 0; i < MAX_MSG_BYTES; i++) begin
      if (i < 32'(bus.in_msg_length)) data_wr[8*i +: 8] = bus.in_msg_data[8*i +: 8];
    end
  end

  // Next pointers and saturating drop counter; a clear coinciding with a drop leaves 1.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_stats)                      drop_cnt_d = drop ? CNT_ONE : '0;
    else if (drop && (drop_cnt_q != '1))  drop_cnt_d = drop_cnt_q + CNT_ONE;
  end

  // Pointer and statistics state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Message storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      len_mem_q[wr_ptr_q[AW-1:0]]  <= bus.in_msg_length;
      data_mem_q[wr_ptr_q[AW-1:0]] <= data_wr;
`ifndef MSGQ_DROP_ERR_EN
      err_mem_q[wr_ptr_q[AW-1:0]]  <= err_wr;
`endif
    end
  end

  // Head entry falls through to the outputs; everything reads zero when empty.
  always_comb begin
    bus.out_valid  = !empty_w;
    bus.out_length = '0;
    bus.out_data   = '0;
    bus.out_error  = 1'b0;
    if (!empty_w) begin
      bus.out_length = len_mem_q[rd_ptr_q[AW-1:0]];
      bus.out_data   = data_mem_q[rd_ptr_q[AW-1:0]];
`ifndef MSGQ_DROP_ERR_EN
      bus.out_error  = err_mem_q[rd_ptr_q[AW-1:0]];
`endif
    end
  end
endmodule

// File: tb/tb_msg_queue.sv
// Scoreboard bench for msg_queue: the reference model tracks queue occupancy
// and the drop counter arithmetically and pushes expected messages; a monitor
// pops and compares on every DUT handshake, a status checker compares flags.
module tb_msg_queue;
  localparam int MB    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int DW    = 8 * MB;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear_stats = 1'b0;
  logic full, empty;
  logic [$clog2(DEPTH):0] level;
  logic [CW-1:0] drop_count;

  msg_queue_if #(.MAX_MSG_BYTES(MB)) bus ();

  msg_queue #(.MAX_MSG_BYTES(MB), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .full(full), .empty(empty),
    .level(level), .drop_count(drop_count), .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   len;
    logic [DW-1:0] data;
    logic          err;
  } msg_t;

  msg_t sb[$];
  int   mcount = 0;
  int   mdrop  = 0;
  int   total  = 0;
  int   bad    = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] len_mask(input logic [15:0] len);
    logic [DW-1:0] one;
    one = 1;
    if (len == 16'd0) return '0;
    if (int'(len) >= MB) return '1;
    return (one << (8 * int'(len))) - one;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = $urandom();
    return d;
  endfunction

  // Reference model: occupancy, drops and expected contents per accepted message.
  bit   m_pop, m_err, m_reject, m_push, m_drop;
  msg_t m_e;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb.delete();
      mcount = 0;
      mdrop  = 0;
    end else begin
      m_pop = (mcount > 0) && bus.out_ready;
      m_err = (bus.in_msg_length == 0) || (int'(bus.in_msg_length) > MB) || bus.in_msg_error;
`ifdef MSGQ_DROP_ERR_EN
      m_reject = m_err;
`else
      m_reject = 1'b0;
`endif
      m_push = 1'b0;
      m_drop = 1'b0;
      if (bus.in_msg_valid) begin
        if (m_reject || (mcount == DEPTH && !m_pop)) m_drop = 1'b1;
        else m_push = 1'b1;
      end
      if (m_push) begin
        m_e.len  = bus.in_msg_length;
        m_e.data = bus.in_msg_data & len_mask(bus.in_msg_length);
`ifdef MSGQ_DROP_ERR_EN
        m_e.err  = 1'b0;
`else
        m_e.err  = m_err;
`endif
        sb.push_back(m_e);
      end
      mcount = mcount + int'(m_push) - int'(m_pop);
      if (clear_stats)                  mdrop = m_drop ? 1 : 0;
      else if (m_drop && mdrop < CMAX)  mdrop = mdrop + 1;
    end
  end

  // Monitor: every handshake must deliver the oldest expected message.
  msg_t mon_e;
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_length", bus.out_length, mon_e.len);
        chk("out_data",   bus.out_data,   mon_e.data);
        chk("out_error",  bus.out_error,  mon_e.err);
      end
    end
  end

  // Status checker: flags, level and drop counter against the model each cycle.
  always @(negedge clk) begin
    chk("level",      level,         mcount);
    chk("full",       full,          mcount == DEPTH);
    chk("empty",      empty,         mcount == 0);
    chk("out_valid",  bus.out_valid, mcount > 0);
    chk("drop_count", drop_count,    mdrop);
    if (mcount == 0) begin
      chk("idle_length", bus.out_length, 0);
      chk("idle_data",   bus.out_data,   0);
      chk("idle_error",  bus.out_error,  0);
    end
  end

  task automatic send(input logic [15:0] len, input logic [DW-1:0] d, input logic err, input logic rdy);
    bus.in_msg_valid  = 1'b1;
    bus.in_msg_length = len;
    bus.in_msg_data   = d;
    bus.in_msg_error  = err;
    bus.out_ready     = rdy;
    @(posedge clk); #1;
    bus.in_msg_valid  = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    bus.out_ready = rdy;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.in_msg_valid  = 1'b0;
    bus.in_msg_length = '0;
    bus.in_msg_data   = '0;
    bus.in_msg_error  = 1'b0;
    bus.out_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2, 1'b0);

    // single short message, all-ones data masked to 5 bytes
    send(16'd5, '1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // overflow: fifth message dropped, then in-order drain
    for (int l = 1; l <= 5; l++) send(16'(l), rand_data(), 1'b0, 1'b0);
    idle(6, 1'b1);

    // full with simultaneous push and pop
    for (int l = 1; l <= 4; l++) send(16'(l + 10), rand_data(), 1'b0, 1'b0);
    send(16'd8, rand_data(), 1'b0, 1'b1);
    idle(6, 1'b1);

    // sanitisation: zero length and oversize length
    send(16'd0,  rand_data(), 1'b0, 1'b1);
    send(16'd40, rand_data(), 1'b0, 1'b1);
    send(16'd32, rand_data(), 1'b1, 1'b1);
    idle(4, 1'b1);

    // drop counter saturation, then clear coinciding with a drop
    for (int l = 1; l <= 4; l++) send(16'(l), rand_data(), 1'b0, 1'b0);
    bus.in_msg_valid  = 1'b1;
    bus.in_msg_length = 16'd3;
    bus.in_msg_error  = 1'b0;
    bus.out_ready     = 1'b0;
    for (int i = 0; i < CMAX + 4; i++) begin
      @(posedge clk); #1;
    end
    clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    bus.in_msg_valid = 1'b0;
    idle(6, 1'b1);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      bus.in_msg_valid  = ($urandom_range(0, 1) == 1);
      bus.in_msg_length = 16'($urandom_range(0, 40));
      bus.in_msg_data   = rand_data();
      bus.in_msg_error  = ($urandom_range(0, 7) == 0);
      bus.out_ready     = ($urandom_range(0, 2) != 0);
      clear_stats       = ($urandom_range(0, 31) == 0);
      @(posedge clk); #1;
    end
    bus.in_msg_valid = 1'b0;
    clear_stats      = 1'b0;
    idle(6, 1'b1);

    // asynchronous reset with messages queued
    for (int l = 1; l <= 3; l++) send(16'(l), rand_data(), 1'b0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_level",     level,         0);
    chk("rst_empty",     empty,         1);
    @(posedge clk); #1;
    rst = 1'b1;
    send(16'd7, rand_data(), 1'b0, 1'b1);

    // bounded drain, then everything expected must have been observed
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb.size() != 0 || mcount != 0); i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain_scoreboard", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
